// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the MIPS_32 fetch-stage PC sequencer.
// The optional alignment check is enabled by defining PC_SEQ_ALIGN_CHECK_EN.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HOLD
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      REDIR,
      EXC
   } pend_kind_t;

   localparam int          DEF_WIDTH     = 32;
   localparam int          DEF_STEP      = 4;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

endpackage : pc_seq_pkg

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer: an exception entry is sticky against redirects.
// With PC_SEQ_ALIGN_CHECK_EN defined it also remembers whether the entry was a misaligned redirect.
module pc_redirect_buf
   import pc_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             wr_exc,
   input  logic [WIDTH-1:0] wr_target,
`ifdef PC_SEQ_ALIGN_CHECK_EN
   input  logic             wr_mis,
   output logic             mis,
`endif
   input  logic             clr,
   output logic [WIDTH-1:0] target,
   output logic             pend_valid
);

   pend_kind_t kind;
   logic       accept;

   // A redirect may only replace an empty slot or another redirect.
   assign accept     = wr && !(kind == EXC && !wr_exc);
   assign pend_valid = (kind != NONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         kind <= NONE;
      end else if (clr) begin
         kind <= NONE;
      end else if (accept) begin
         kind <= wr_exc ? EXC : REDIR;
      end
   end

   // NOTE: the stored target is a data register qualified by kind, so it
   // needs no reset; only the control state does.
   always_ff @(posedge clk) begin
      if (!clr && accept) begin
         target <= wr_target;
      end
   end

`ifdef PC_SEQ_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         mis <= 1'b0;
      end else if (clr) begin
         mis <= 1'b0;
      end else if (accept) begin
         mis <= wr_mis;
      end
   end
`endif

endmodule : pc_redirect_buf

// File: rtl/pc_sequencer.sv
// Registered fetch PC with step increment, exception/redirect priority, stall hold and pending buffer.
// Optional feature: define PC_SEQ_ALIGN_CHECK_EN to trap misaligned redirect targets and drive misalign.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               STEP      = DEF_STEP,
   parameter logic [WIDTH-1:0] RESET_VEC = DEF_RESET_VEC[WIDTH-1:0],
   parameter logic [WIDTH-1:0] EXC_VEC   = DEF_EXC_VEC[WIDTH-1:0]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redir_valid,
   input  logic [WIDTH-1:0] redir_target,
   input  logic             exc_valid,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic             pc_valid,
   output logic             pend_valid
`ifdef PC_SEQ_ALIGN_CHECK_EN
   ,
   output logic             misalign
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] redir_eff;
   logic [WIDTH-1:0] buf_target;
   logic             advance;
   logic             capture;

   assign pc_seq  = pc + WIDTH'(STEP);
   assign advance = (state != BOOT) && !stall;
   assign capture = (exc_valid || redir_valid) && (state == BOOT || stall);

`ifdef PC_SEQ_ALIGN_CHECK_EN
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   logic redir_mis;
   logic buf_mis;
   logic sel_mis;

   assign redir_mis = |(redir_target & ALIGN_MASK);
   assign redir_eff = redir_mis ? EXC_VEC : redir_target;
   assign sel_mis   = advance && !exc_valid &&
                      (redir_valid ? redir_mis : (pend_valid && buf_mis));
`else
   assign redir_eff = redir_target;
`endif

   pc_redirect_buf #(
      .WIDTH(WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr        (capture),
      .wr_exc    (exc_valid),
      .wr_target (exc_valid ? EXC_VEC : redir_eff),
`ifdef PC_SEQ_ALIGN_CHECK_EN
      .wr_mis    (!exc_valid && redir_mis),
      .mis       (buf_mis),
`endif
      .clr       (advance),
      .target    (buf_target),
      .pend_valid(pend_valid)
   );

   // NOTE: every output of this block gets a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      pc_next   = pc;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (stall && (exc_valid || redir_valid)) state_nxt = HOLD;
         HOLD:    if (!stall) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
      if (advance) begin
         if (exc_valid)        pc_next = EXC_VEC;
         else if (redir_valid) pc_next = redir_eff;
         else if (pend_valid)  pc_next = buf_target;
         else                  pc_next = pc_seq;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BOOT;
         pc       <= RESET_VEC;
         pc_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_next;
         // Every non-reset edge leaves BOOT or later, so the PC is valid from here on.
         pc_valid <= 1'b1;
      end
   end

`ifdef PC_SEQ_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) misalign <= 1'b0;
      else     misalign <= sel_mis;
   end
`endif

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: a 32-bit instance and an 8-bit wrap instance.
// Expectations for the misaligned redirect follow PC_SEQ_ALIGN_CHECK_EN.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        exc_valid;
   logic [31:0] pc;
   logic [31:0] pc_seq;
   logic        pc_valid;
   logic        pend_valid;

   logic        rst_b;
   logic [7:0]  pc_b;
   logic [7:0]  pc_seq_b;
   logic        pc_valid_b;
   logic        pend_valid_b;

`ifdef PC_SEQ_ALIGN_CHECK_EN
   logic        misalign;
   logic        misalign_b;
`endif

   int vectors   = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redir_valid (redir_valid),
      .redir_target(redir_target),
      .exc_valid   (exc_valid),
      .pc          (pc),
      .pc_seq      (pc_seq),
      .pc_valid    (pc_valid),
      .pend_valid  (pend_valid)
`ifdef PC_SEQ_ALIGN_CHECK_EN
      ,
      .misalign    (misalign)
`endif
   );

   pc_sequencer #(
      .WIDTH    (8),
      .STEP     (4),
      .RESET_VEC(8'hF0),
      .EXC_VEC  (8'h80)
   ) dut_b (
      .clk         (clk),
      .rst         (rst_b),
      .stall       (1'b0),
      .redir_valid (1'b0),
      .redir_target(8'h00),
      .exc_valid   (1'b0),
      .pc          (pc_b),
      .pc_seq      (pc_seq_b),
      .pc_valid    (pc_valid_b),
      .pend_valid  (pend_valid_b)
`ifdef PC_SEQ_ALIGN_CHECK_EN
      ,
      .misalign    (misalign_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      rst_b        = 1'b1;
      stall        = 1'b0;
      redir_valid  = 1'b0;
      redir_target = 32'h0;
      exc_valid    = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_valid", {31'b0, pc_valid}, 32'h0);
      chk("rst_pend", {31'b0, pend_valid}, 32'h0);
      chk("rst_b_pc", {24'b0, pc_b}, 32'hF0);

      // Release: BOOT cycle, then sequential fetch
      rst = 1'b0;
      chk("boot_pc_valid", {31'b0, pc_valid}, 32'h0);
      tick();
      chk("run_pc0", pc, 32'h0);
      chk("run_valid", {31'b0, pc_valid}, 32'h1);
      chk("run_seq0", pc_seq, 32'h4);
      tick();
      chk("run_pc4", pc, 32'h4);
      tick();
      chk("run_pc8", pc, 32'h8);
      chk("run_seq8", pc_seq, 32'hC);

      // Unstalled redirect
      redir_valid = 1'b1; redir_target = 32'h100;
      tick();
      chk("redir_pc", pc, 32'h100);
      redir_valid = 1'b0;
      tick();
      chk("redir_next", pc, 32'h104);
      chk("redir_seq", pc_seq, 32'h108);

      // Redirect held behind a 3-cycle stall
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h200;
      tick();
      chk("stall1_pc", pc, 32'h104);
      chk("stall1_pend", {31'b0, pend_valid}, 32'h1);
      redir_valid = 1'b0;
      tick();
      chk("stall2_pc", pc, 32'h104);
      tick();
      chk("stall3_pc", pc, 32'h104);
      chk("stall3_pend", {31'b0, pend_valid}, 32'h1);
      chk("stall3_valid", {31'b0, pc_valid}, 32'h1);
      stall = 1'b0;
      tick();
      chk("release_pc", pc, 32'h200);
      chk("release_pend", {31'b0, pend_valid}, 32'h0);
      tick();
      chk("release_next", pc, 32'h204);

      // Buffered exception is not overwritten by a later redirect
      stall = 1'b1; exc_valid = 1'b1;
      tick();
      chk("exc_hold_pc", pc, 32'h204);
      exc_valid = 1'b0; redir_valid = 1'b1; redir_target = 32'h300;
      tick();
      chk("exc_sticky_pend", {31'b0, pend_valid}, 32'h1);
      redir_valid = 1'b0; stall = 1'b0;
      tick();
      chk("exc_sticky_pc", pc, 32'h80);
      tick();
      chk("exc_sticky_next", pc, 32'h84);

      // Buffered redirect loses to a same-cycle exception on release
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h400;
      tick();
      chk("redir_buf_pc", pc, 32'h84);
      redir_valid = 1'b0; stall = 1'b0; exc_valid = 1'b1;
      tick();
      chk("exc_beats_buf", pc, 32'h80);
      chk("exc_beats_pend", {31'b0, pend_valid}, 32'h0);
      exc_valid = 1'b0;
      tick();
      chk("exc_beats_next", pc, 32'h84);

      // Newer redirect replaces an older buffered redirect
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h500;
      tick();
      redir_target = 32'h600;
      tick();
      stall = 1'b0; redir_valid = 1'b0;
      tick();
      chk("redir_overwrite", pc, 32'h600);

      // Misaligned redirect target
      redir_valid = 1'b1; redir_target = 32'h102;
      tick();
      redir_valid = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      chk("misalign_pc", pc, 32'h80);
      chk("misalign_pulse", {31'b0, misalign}, 32'h1);
      tick();
      chk("misalign_next", pc, 32'h84);
      chk("misalign_clear", {31'b0, misalign}, 32'h0);
`else
      chk("unaligned_pc", pc, 32'h102);
      tick();
      chk("unaligned_next", pc, 32'h106);
`endif

      // Reset in the middle of HOLD discards the buffer
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h700;
      tick();
      chk("hold_pend", {31'b0, pend_valid}, 32'h1);
      redir_valid = 1'b0; rst = 1'b1;
      tick();
      chk("midhold_rst_pc", pc, 32'h0);
      chk("midhold_rst_pend", {31'b0, pend_valid}, 32'h0);
      chk("midhold_rst_valid", {31'b0, pc_valid}, 32'h0);

      // Request arriving during BOOT is buffered and applied in RUN
      rst = 1'b0; stall = 1'b0; redir_valid = 1'b1; redir_target = 32'h900;
      tick();
      chk("boot_cap_pc", pc, 32'h0);
      chk("boot_cap_pend", {31'b0, pend_valid}, 32'h1);
      chk("boot_cap_valid", {31'b0, pc_valid}, 32'h1);
      redir_valid = 1'b0;
      tick();
      chk("boot_cap_apply", pc, 32'h900);
      chk("boot_cap_clear", {31'b0, pend_valid}, 32'h0);

      // 8-bit instance wraps 0xFC -> 0x00
      rst_b = 1'b0;
      tick();
      chk("b_boot_pc", {24'b0, pc_b}, 32'hF0);
      chk("b_valid", {31'b0, pc_valid_b}, 32'h1);
      tick();
      tick();
      tick();
      chk("b_pc_fc", {24'b0, pc_b}, 32'hFC);
      chk("b_seq_wrap", {24'b0, pc_seq_b}, 32'h00);
      tick();
      chk("b_pc_wrap", {24'b0, pc_b}, 32'h00);
      chk("b_seq_after", {24'b0, pc_seq_b}, 32'h04);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS_32 fetch stage, extending the stateless increment-by-constant adder into a registered PC with a configurable step, reset and exception vectors, stall handling and a one-entry pending-redirect buffer. It sits between the branch/jump resolution logic and the instruction-memory address port. Each cycle it presents the current fetch address and the next sequential address.

## Interface
- `WIDTH`, 32: PC width in bits.
- `STEP`, 4: sequential increment in bytes. Must be a power of two, at least 1.
- `RESET_VEC`, 0: PC value after reset, `WIDTH` bits.
- `EXC_VEC`, 32'h0000_0080: exception target, `WIDTH` bits.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: fetch cannot accept a new address, so hold `pc`.
- `redir_valid` in 1: branch or jump redirect request.
- `redir_target` in WIDTH: redirect target address.
- `exc_valid` in 1: exception request. The target is `EXC_VEC`.
- `pc` out WIDTH: current fetch address.
- `pc_seq` out WIDTH: `pc + STEP`, combinational, modulo 2^WIDTH.
- `pc_valid` out 1: `pc` is a valid fetch address.
- `pend_valid` out 1: the pending-redirect buffer is occupied.
- `misalign` out 1: present only with `PC_SEQ_ALIGN_CHECK_EN`.

## Operation
The FSM has three states: BOOT, RUN and HOLD.

Reset values:
- `pc = RESET_VEC`, `pc_valid = 0`, `pend_valid = 0`, `misalign = 0`, state = BOOT.
- `rst` has priority over every other input in every state, including in the middle of a HOLD. The pending buffer is discarded.

Next-PC source priority, applied whenever the PC is allowed to advance:
1. `exc_valid` selects `EXC_VEC`.
2. `redir_valid` selects `redir_target`.
3. The pending buffer selects its stored target.
4. Otherwise `pc_seq`.

BOOT:
- Lasts one cycle after `rst` deasserts. `pc_valid` goes to 1 and the state goes to RUN.
- `pc` stays at `RESET_VEC`.
- Requests arriving in BOOT are captured into the buffer as in HOLD.

RUN:
- With `stall=0`, `pc` loads the priority result. Any buffer entry that was used is cleared.
- With `stall=1`, `pc` holds.
  - If `exc_valid` or `redir_valid` is asserted, the request is written into the buffer and the state goes to HOLD.
  - Otherwise the state stays RUN.

HOLD:
- `pc` holds while `stall=1`.
- A new request overwrites the buffer under these rules:
  - An exception always overwrites.
  - A redirect overwrites only a redirect entry. It never overwrites an exception entry.
- When `stall` falls, the priority selection applies. A same-cycle exception or redirect beats the buffered one. The buffer clears and the state goes to RUN.

General rules:
- `pend_valid` is 1 exactly when the buffer holds an entry.
- `pc_valid` stays at 1 from RUN onward, including through stalls.
- All arithmetic is unsigned, modulo 2^WIDTH. `pc = {WIDTH{1'b1}} - STEP + 1` advances to 0. No carry out is produced.

## Timing
- Redirect or exception to `pc` update takes 1 cycle: the request is sampled at edge N and the new `pc` is visible after edge N.
- A redirect held behind a stall applies on the first edge where `stall=0`.
- `pc_seq` is combinational from `pc`, with no extra latency.
- The first valid fetch occurs 2 edges after the edge that samples `rst=1` followed by `rst=0`.

## Configuration
- `PC_SEQ_ALIGN_CHECK_EN` defined:
  - Any selected `redir_target` whose low log2(STEP) bits are nonzero is replaced by `EXC_VEC`.
  - `misalign` pulses 1 for the one cycle after that load.
  - Buffered entries are checked when they are written.
- `PC_SEQ_ALIGN_CHECK_EN` undefined:
  - There is no `misalign` port.
  - The target is loaded unchanged.

## Structure
- A shared package `pc_seq_pkg` holds:
  - the FSM state enum (BOOT, RUN, HOLD);
  - the buffer-entry kind enum (NONE, REDIR, EXC);
  - the default vector constants.
- One sub-module, `pc_redirect_buf`, implements the one-entry buffer:
  - write and clear controls;
  - the exception-sticky overwrite rule;
  - outputs for the stored target and `pend_valid`.
- `pc_sequencer` owns the FSM, the PC register and the priority mux.

## Test plan
- Reset release, no stall → `pc_valid` 0 for one cycle with `pc=0`, then `pc` = 0, 4, 8, 12 on successive cycles; `pc_seq` always `pc+4`.
- `redir_valid=1`, `redir_target=0x100`, `stall=0` at `pc=0x8` → next cycle `pc=0x100`, then 0x104.
- `stall=1` for 3 cycles with a redirect to 0x200 in the first stall cycle → `pc` frozen, `pend_valid=1`; the cycle after `stall` falls gives `pc=0x200` and `pend_valid=0`.
- Within one stall: buffered exception, then a redirect to 0x300 → after release `pc=0x80`. Separately, a buffered redirect plus a same-cycle `exc_valid` on release → `pc=0x80`.
- `WIDTH=8`, `STEP=4`, `pc=0xFC` → next `pc=0x00`. `rst` asserted mid-HOLD → `pc=RESET_VEC` and `pend_valid=0` the next cycle.
- With `PC_SEQ_ALIGN_CHECK_EN` defined, a redirect to 0x102 → `pc=0x80` and a `misalign` 1-cycle pulse. Without the macro → `pc=0x102`.
